// File: rtl/disp_pkg.sv
// Shared definitions for the serial display arbiter.
//   state_e : transfer engine states
//   CH_SEG  : channel id of the 7-segment chain (req/grant bit 0)
//   CH_LED  : channel id of the LED chain (req/grant bit 1)
package disp_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT_LO,
      SHIFT_HI,
      LATCH
   } state_e;

   localparam logic CH_SEG = 1'b0;
   localparam logic CH_LED = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (combinational).
//   req       : request per channel, indexed by CH_SEG / CH_LED
//   grant_en  : arbitration allowed this cycle
//   last      : channel served most recently
//   grant     : one-hot grant (all zero when disabled or nothing requested)
//   last_next : value of last after this cycle's grant
module rr_arb2
   import disp_pkg::*;
(
   input  logic [1:0] req,
   input  logic       grant_en,
   input  logic       last,
   output logic [1:0] grant,
   output logic       last_next
);

   always_comb begin
      grant     = 2'b00;
      last_next = last;
      if (grant_en) begin
         if (req[CH_SEG] && req[CH_LED]) begin
            // Tie goes to the channel not served last.
            if (last == CH_LED) begin
               grant[CH_SEG] = 1'b1;
            end else begin
               grant[CH_LED] = 1'b1;
            end
         end else begin
            grant = req;
         end
         if (grant[CH_SEG]) begin
            last_next = CH_SEG;
         end else if (grant[CH_LED]) begin
            last_next = CH_LED;
         end
      end
   end

endmodule

// File: rtl/serial_disp_arbiter.sv
// Shared shift-out engine for the 7-segment chain and the LED chain.
// Grants the two channels round-robin, shifts the granted word out MSB-first
// on that chain's clk/sout pins, then pulses the chain's parallel-enable.
//   clk_100mhz, rst             : system clock, synchronous active-high reset
//   seg_req/seg_data/seg_ack    : 7-seg requester handshake (data taken in ack cycle)
//   led_req/led_data/led_ack    : LED requester handshake (data taken in ack cycle)
//   seg_clk/sout/clrn/pen       : 7-seg chain pins
//   led_clk/sout/clrn/pen       : LED chain pins
//   busy                        : high from LOAD through LATCH
module serial_disp_arbiter
   import disp_pkg::*;
#(
   parameter int unsigned SEG_BITS = 64,
   parameter int unsigned LED_BITS = 16,
   parameter int unsigned CLK_DIV  = 4
) (
   input  logic                clk_100mhz,
   input  logic                rst,
   input  logic                seg_req,
   input  logic [SEG_BITS-1:0] seg_data,
   output logic                seg_ack,
   input  logic                led_req,
   input  logic [LED_BITS-1:0] led_data,
   output logic                led_ack,
   output logic                seg_clk,
   output logic                seg_sout,
   output logic                seg_clrn,
   output logic                seg_pen,
   output logic                led_clk,
   output logic                led_sout,
   output logic                led_clrn,
   output logic                led_pen,
   output logic                busy
);

   localparam int unsigned CW = $clog2(SEG_BITS) + 1;
   localparam int unsigned PW = $clog2(CLK_DIV) + 1;
   localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);
   localparam logic [CW-1:0] SEG_CNT    = CW'(SEG_BITS);
   localparam logic [CW-1:0] LED_CNT    = CW'(LED_BITS);

   state_e              state_q;
   logic                last_q;
   logic                chan_q;
   logic [SEG_BITS-1:0] shreg_q;
   logic [CW-1:0]       bit_cnt_q;
   logic [PW-1:0]       phase_q;
   logic                clrn_q;

   logic [1:0] grant;
   logic       last_next;
   logic       phase_done;

   assign phase_done = (phase_q == PHASE_LAST);

   rr_arb2 u_arb (
      .req       ({led_req, seg_req}),
      .grant_en  (state_q == IDLE),
      .last      (last_q),
      .grant     (grant),
      .last_next (last_next)
   );

   always_ff @(posedge clk_100mhz) begin
      if (rst) begin
         state_q   <= IDLE;
         last_q    <= CH_LED;
         chan_q    <= CH_SEG;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         phase_q   <= '0;
         clrn_q    <= 1'b0;
      end else begin
         clrn_q <= 1'b1;
         unique case (state_q)
            IDLE: begin
               if (|grant) begin
                  state_q <= LOAD;
                  chan_q  <= grant[CH_LED] ? CH_LED : CH_SEG;
                  last_q  <= last_next;
               end
            end
            LOAD: begin
               phase_q <= '0;
               state_q <= SHIFT_LO;
               if (chan_q == CH_SEG) begin
                  shreg_q   <= seg_data;
                  bit_cnt_q <= SEG_CNT;
               end else begin
                  // Left-justify so the LED word's MSB sits at the shared MSB tap.
                  shreg_q   <= SEG_BITS'(led_data) << (SEG_BITS - LED_BITS);
                  bit_cnt_q <= LED_CNT;
               end
            end
            SHIFT_LO: begin
               if (phase_done) begin
                  phase_q <= '0;
                  state_q <= SHIFT_HI;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            SHIFT_HI: begin
               if (phase_done) begin
                  phase_q   <= '0;
                  shreg_q   <= shreg_q << 1;
                  bit_cnt_q <= bit_cnt_q - 1'b1;
                  state_q   <= (bit_cnt_q == CW'(1)) ? LATCH : SHIFT_LO;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            LATCH: begin
               if (phase_done) begin
                  phase_q <= '0;
                  state_q <= IDLE;
               end else begin
                  phase_q <= phase_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Pins decode from registered state only; the idle chain stays all-zero.
   logic in_shift;
   logic msb;
   logic is_seg;

   always_comb begin
      in_shift = (state_q == SHIFT_LO) || (state_q == SHIFT_HI);
      msb      = shreg_q[SEG_BITS-1];
      is_seg   = (chan_q == CH_SEG);

      seg_ack  = (state_q == LOAD) && is_seg;
      led_ack  = (state_q == LOAD) && !is_seg;
      seg_clk  = (state_q == SHIFT_HI) && is_seg;
      led_clk  = (state_q == SHIFT_HI) && !is_seg;
      seg_sout = in_shift && is_seg && msb;
      led_sout = in_shift && !is_seg && msb;
      seg_pen  = (state_q == LATCH) && is_seg;
      led_pen  = (state_q == LATCH) && !is_seg;
      seg_clrn = clrn_q;
      led_clrn = clrn_q;
      busy     = (state_q != IDLE);
   end

endmodule
